// File: rtl/formation_pkg.sv
// Shared types and helpers for the alien formation controller.
// Combinational only: cell decode and population count, no state.
// No flow control; callers evaluate these every cycle.
package formation_pkg;

    typedef enum logic [1:0] {
        FE_RUN     = 2'd0,
        FE_CLEAR   = 2'd1,
        FE_INVADED = 2'd2
    } fe_state_e;

    typedef struct packed {
        logic       hit;
        logic [3:0] row;
        logic [3:0] col;
    } cell_t;

    localparam int MAX_CELLS = 128;

    // hit means the position lies inside a sprite of an in-range cell; liveness is checked by the caller
    function automatic cell_t cell_decode(
        input logic [15:0] pos_x,
        input logic [15:0] pos_y,
        input logic [15:0] org_x,
        input logic [15:0] org_y,
        input int          sx_log2,
        input int          sy_log2,
        input int          cell_w,
        input int          cell_h,
        input int          num_rows,
        input int          num_cols
    );
        logic [16:0] dx;
        logic [16:0] dy;
        logic [15:0] cx;
        logic [15:0] cy;
        logic [15:0] fx;
        logic [15:0] fy;
        cell_t       res;
        dx = {1'b0, pos_x} - {1'b0, org_x};
        dy = {1'b0, pos_y} - {1'b0, org_y};
        cx = dx[15:0] >> sx_log2;
        cy = dy[15:0] >> sy_log2;
        fx = dx[15:0] & ((16'd1 << sx_log2) - 16'd1);
        fy = dy[15:0] & ((16'd1 << sy_log2) - 16'd1);
        res.hit = !dx[16] && !dy[16]
               && (int'(cx) < num_cols) && (int'(cy) < num_rows)
               && (int'(fx) < cell_w) && (int'(fy) < cell_h);
        res.row = cy[3:0];
        res.col = cx[3:0];
        return res;
    endfunction

    function automatic logic [7:0] popcount(input logic [MAX_CELLS-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < MAX_CELLS; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/formation_bounds.sv
// Extent of the live formation: leftmost/rightmost occupied column, lowest occupied row.
// Purely combinational, zero latency.
// No flow control.
module formation_bounds
    import formation_pkg::*;
#(
    parameter int NUM_ROWS = 5,
    parameter int NUM_COLS = 11
) (
    input  logic [NUM_ROWS*NUM_COLS-1:0] alive_matrix,
    output logic [3:0]                   c_min,
    output logic [3:0]                   c_max,
    output logic [3:0]                   r_max,
    output logic                         any_alive
);

    logic [NUM_COLS-1:0] col_any;
    logic [NUM_ROWS-1:0] row_any;

    always_comb begin
        col_any = '0;
        row_any = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (alive_matrix[r*NUM_COLS+c]) begin
                    col_any[c] = 1'b1;
                    row_any[r] = 1'b1;
                end
            end
        end
    end

    // Scan order picks the extreme index: last assignment wins.
    always_comb begin
        c_min = '0;
        c_max = '0;
        r_max = '0;
        for (int c = NUM_COLS - 1; c >= 0; c--) begin
            if (col_any[c]) c_min = 4'(c);
        end
        for (int c = 0; c < NUM_COLS; c++) begin
            if (col_any[c]) c_max = 4'(c);
        end
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_any[r]) r_max = 4'(r);
        end
    end

    assign any_alive = |alive_matrix;

endmodule

// File: rtl/formation_engine.sv
// Alien formation controller: alive matrix, shared origin stepping, hit resolution, pixel render.
// alien_pixel and hit_ack are registered (1 cycle); status outputs are combinational from state.
// No backpressure: frame_tick, hit_valid and wave_start are sampled every cycle.
module formation_engine
    import formation_pkg::*;
#(
    parameter int NUM_ROWS   = 5,
    parameter int NUM_COLS   = 11,
    parameter int SX_LOG2    = 5,
    parameter int SY_LOG2    = 5,
    parameter int CELL_W     = 16,
    parameter int CELL_H     = 16,
    parameter int START_X    = 40,
    parameter int START_Y    = 40,
    parameter int MIN_X      = 8,
    parameter int MAX_X      = 632,
    parameter int STEP_X     = 4,
    parameter int DROP_Y     = 8,
    parameter int INVADE_Y   = 440,
    parameter int MIN_PERIOD = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         frame_tick,
    input  logic [15:0]                  scan_x,
    input  logic [15:0]                  scan_y,
    input  logic                         hit_valid,
    input  logic [15:0]                  hit_x,
    input  logic [15:0]                  hit_y,
    input  logic                         wave_start,
    output logic                         alien_pixel,
    output logic                         hit_ack,
    output logic [NUM_ROWS*NUM_COLS-1:0] alive_matrix,
    output logic [NUM_ROWS*NUM_COLS-1:0] armed_matrix,
    output logic [7:0]                   alive_count,
    output logic [15:0]                  origin_x,
    output logic [15:0]                  origin_y,
    output logic [3:0]                   level,
    output logic                         wave_clear,
    output logic                         invaded
);

    localparam int N = NUM_ROWS * NUM_COLS;

    fe_state_e             state_q;
    fe_state_e             state_d;
    logic [N-1:0]          alive_q;
    logic [15:0]           ox_q;
    logic [15:0]           oy_q;
    logic                  dir_left_q;
    logic [3:0]            level_q;
    logic [7:0]            cnt_q;
    logic                  pix_q;
    logic                  ack_q;

    logic [3:0]            c_min;
    logic [3:0]            c_max;
    logic [3:0]            r_max;
    logic                  any_alive;
    logic [MAX_CELLS-1:0]  alive_pad;
    logic [7:0]            alive_cnt;
    logic [7:0]            period;
    logic                  timer_hit;
    logic                  move;
    logic                  descend;
    logic                  reached;
    logic [16:0]           right_edge;
    logic [16:0]           left_edge;
    logic [16:0]           bottom_edge;
    cell_t                 hit_cell;
    cell_t                 pix_cell;
    logic [6:0]            hit_idx;
    logic [6:0]            pix_idx;
    logic                  hit_kill;
    logic                  pix_d;
    logic [N-1:0]          kill_mask;
    logic [3:0]            level_next;
    logic [15:0]           restart_y;

    formation_bounds #(
        .NUM_ROWS (NUM_ROWS),
        .NUM_COLS (NUM_COLS)
    ) u_bounds (
        .alive_matrix (alive_q),
        .c_min        (c_min),
        .c_max        (c_max),
        .r_max        (r_max),
        .any_alive    (any_alive)
    );

    assign alive_pad = MAX_CELLS'(alive_q);
    assign alive_cnt = popcount(alive_pad);
    assign period    = (alive_cnt > 8'(MIN_PERIOD)) ? alive_cnt : 8'(MIN_PERIOD);
    assign timer_hit = (state_q == FE_RUN) && frame_tick
                    && (({1'b0, cnt_q} + 9'd1) >= {1'b0, period});
    assign move      = timer_hit && any_alive;

    // 17-bit edges so a formation near the top of the 16-bit range never wraps below a wall.
    assign right_edge  = {1'b0, ox_q} + ({13'd0, c_max} << SX_LOG2) + 17'(CELL_W);
    assign left_edge   = {1'b0, ox_q} + ({13'd0, c_min} << SX_LOG2);
    assign bottom_edge = {1'b0, oy_q} + ({13'd0, r_max} << SY_LOG2) + 17'(CELL_H);
    assign descend     = dir_left_q ? (left_edge < 17'(MIN_X + STEP_X))
                                    : ((right_edge + 17'(STEP_X)) > 17'(MAX_X));
    assign reached     = any_alive && (bottom_edge >= 17'(INVADE_Y));

    assign hit_cell = cell_decode(hit_x, hit_y, ox_q, oy_q, SX_LOG2, SY_LOG2,
                                  CELL_W, CELL_H, NUM_ROWS, NUM_COLS);
    assign hit_idx  = {3'd0, hit_cell.row} * 7'(NUM_COLS) + {3'd0, hit_cell.col};
    assign hit_kill = hit_valid && !wave_start && (state_q == FE_RUN)
                   && hit_cell.hit && alive_pad[hit_idx];
    assign kill_mask = hit_kill ? (N'(1) << hit_idx) : '0;

    assign pix_cell = cell_decode(scan_x, scan_y, ox_q, oy_q, SX_LOG2, SY_LOG2,
                                  CELL_W, CELL_H, NUM_ROWS, NUM_COLS);
    assign pix_idx  = {3'd0, pix_cell.row} * 7'(NUM_COLS) + {3'd0, pix_cell.col};
    assign pix_d    = pix_cell.hit && alive_pad[pix_idx];

    assign level_next = ((state_q == FE_CLEAR) && (level_q != 4'hf)) ? level_q + 4'd1 : level_q;
    assign restart_y  = 16'(START_Y + int'(level_next) * DROP_Y);

    always_comb begin : p_armed
        logic below;
        armed_matrix = '0;
        below        = 1'b0;
        for (int c = 0; c < NUM_COLS; c++) begin
            below = 1'b0;
            for (int r = NUM_ROWS - 1; r >= 0; r--) begin
                armed_matrix[r*NUM_COLS+c] = alive_q[r*NUM_COLS+c] && !below;
                below = below | alive_q[r*NUM_COLS+c];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FE_RUN: begin
                if (alive_cnt == 8'd0)  state_d = FE_CLEAR;
                else if (reached)       state_d = FE_INVADED;
            end
            default: ;
        endcase
        if (wave_start) state_d = FE_RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FE_RUN;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q    <= '1;
            ox_q       <= 16'(START_X);
            oy_q       <= 16'(START_Y);
            dir_left_q <= 1'b0;
            level_q    <= 4'd0;
            cnt_q      <= 8'd0;
            pix_q      <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            pix_q <= pix_d;
            ack_q <= hit_kill;
            if (wave_start) begin
                alive_q    <= '1;
                ox_q       <= 16'(START_X);
                oy_q       <= restart_y;
                dir_left_q <= 1'b0;
                level_q    <= level_next;
                cnt_q      <= 8'd0;
            end else begin
                alive_q <= alive_q & ~kill_mask;
                if (timer_hit)                             cnt_q <= 8'd0;
                else if ((state_q == FE_RUN) && frame_tick) cnt_q <= cnt_q + 8'd1;
                if (move) begin
                    if (descend) begin
                        oy_q       <= oy_q + 16'(DROP_Y);
                        dir_left_q <= ~dir_left_q;
                    end else if (dir_left_q) begin
                        ox_q <= ox_q - 16'(STEP_X);
                    end else begin
                        ox_q <= ox_q + 16'(STEP_X);
                    end
                end
            end
        end
    end

    assign alien_pixel  = pix_q;
    assign hit_ack      = ack_q;
    assign alive_matrix = alive_q;
    assign alive_count  = alive_cnt;
    assign origin_x     = ox_q;
    assign origin_y     = oy_q;
    assign level        = level_q;
    assign wave_clear   = (state_q == FE_CLEAR);
    assign invaded      = (state_q == FE_INVADED);

endmodule
